// File: rtl/insn_fetch_unit.sv
// Instruction fetch unit: fetches one word per pc, classifies its opcode into a
// one-hot code and halts on illegal opcodes or misaligned branch targets.
module insn_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_load,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] insn,
  output logic [9:0]  code,
  output logic        insn_valid,
  output logic        fault
);

  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [9:0]  rd_code;
  logic        take_insn, take_pc, set_fault, clr_valid;

  // Every listed opcode ends in 2'b11, so matching all seven bits also
  // enforces the compressed-encoding exclusion.
  function automatic logic [9:0] decode(input logic [6:0] op);
    case (op)
      7'b0110011: decode = 10'b00_0000_0001;
      7'b0010011: decode = 10'b00_0000_0010;
      7'b0000011: decode = 10'b00_0000_0100;
      7'b0100011: decode = 10'b00_0000_1000;
      7'b1100011: decode = 10'b00_0001_0000;
      7'b1101111: decode = 10'b00_0010_0000;
      7'b1100111: decode = 10'b00_0100_0000;
      7'b0110111: decode = 10'b00_1000_0000;
      7'b0010111: decode = 10'b01_0000_0000;
      7'b1110011,
      7'b0001111: decode = 10'b10_0000_0000;
      default:    decode = 10'b00_0000_0000;
    endcase
  endfunction

  assign rd_code   = decode(imem_rdata[6:0]);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    take_insn = 1'b0;
    take_pc   = 1'b0;
    set_fault = 1'b0;
    clr_valid = 1'b0;
    case (state_q)
      FETCH: begin
        // Request is masked while reset is held so memory sees no stray read.
        imem_req = reset;
        if (imem_ack) begin
          take_insn = 1'b1;
          if (rd_code == 10'b0) begin
            set_fault = 1'b1;
            state_d   = HALT;
          end else begin
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (pc_load) begin
          clr_valid = 1'b1;
          if (pc_next[1:0] == 2'b00) begin
            take_pc = 1'b1;
            state_d = FETCH;
          end else begin
            set_fault = 1'b1;
            state_d   = HALT;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      insn       <= NOP;
      code       <= 10'b0;
      insn_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      if (take_insn) begin
        insn       <= imem_rdata;
        code       <= rd_code;
        insn_valid <= 1'b1;
      end
      if (take_pc)   pc         <= pc_next;
      if (clr_valid) insn_valid <= 1'b0;
      if (set_fault) fault      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Directed plus randomized bench for insn_fetch_unit against a behavioural
// model that tracks what the fetch unit should be holding each cycle.
module tb_insn_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] insn;
  logic [9:0]  code;
  logic        insn_valid;
  logic        fault;

  insn_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_load(pc_load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .insn(insn), .code(code),
    .insn_valid(insn_valid), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: "busy" = waiting on memory, "dead" = halted until reset.
  logic [31:0] m_pc, m_insn;
  logic [9:0]  m_code;
  logic        m_valid, m_fault, m_busy, m_dead;

  // Opcode table indexed by code bit; SYSTEM and FENCE share bit 9.
  logic [6:0] op_tab [0:10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};

  function automatic logic [9:0] m_class(input logic [31:0] w);
    m_class = 10'b0;
    for (int i = 0; i < 11; i++)
      if (w[6:0] == op_tab[i]) m_class = 10'b1 << ((i == 10) ? 9 : i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic ld, input logic [31:0] nx,
                            input logic ak, input logic [31:0] rd);
    if (!r) begin
      m_pc = RESET_PC; m_insn = NOP; m_code = '0; m_valid = 0; m_fault = 0;
      m_busy = 1; m_dead = 0;
    end else if (m_dead) begin
    end else if (m_busy) begin
      if (ak) begin
        m_insn = rd; m_code = m_class(rd); m_valid = 1; m_busy = 0;
        if (m_code == 0) begin m_fault = 1; m_dead = 1; end
      end
    end else if (ld) begin
      m_valid = 0;
      if (nx[1:0] == 2'b00) begin m_pc = nx; m_busy = 1; end
      else begin m_fault = 1; m_dead = 1; end
    end
  endtask

  // One clock: drive inputs, check the combinational request, clock, check state.
  task automatic cyc(input logic r, input logic ld, input logic [31:0] nx,
                     input logic ak, input logic [31:0] rd);
    logic exp_req;
    reset = r; pc_load = ld; pc_next = nx; imem_ack = ak; imem_rdata = rd;
    #1;
    exp_req = r && m_busy && !m_dead;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    model_edge(r, ld, nx, ak, rd);
    #1;
    chk("pc", pc, m_pc);
    chk("insn", insn, m_insn);
    chk("code", {22'b0, code}, {22'b0, m_code});
    chk("insn_valid", {31'b0, insn_valid}, {31'b0, m_valid});
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
  endtask

  initial begin
    int unsigned u, v;
    logic [31:0] w, nx;
    m_pc = 'x; m_insn = 'x; m_code = 'x; m_valid = 'x; m_fault = 'x;
    m_busy = 0; m_dead = 0;
    reset = 0; pc_load = 0; pc_next = 0; imem_ack = 0; imem_rdata = 0;
    @(posedge clk); #1;

    // Reset state, then first fetch of a branch word.
    cyc(0, 0, 0, 1, 32'h1234_5673);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'h0052_0463);
    chk("b33_code", {22'b0, code}, 32'h0000_0010);
    chk("b33_insn", insn, 32'h0052_0463);

    // Jump to 8 with a slow memory; a pc_load strobe mid-fetch is dropped.
    cyc(1, 1, 32'h0000_0008, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 32'h0000_0040, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'h00A0_0093);
    chk("b34_code", {22'b0, code}, 32'h0000_0002);
    chk("b34_pc", pc, 32'h0000_0008);

    // Top-of-address-space target is taken as-is.
    cyc(1, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(1, 0, 0, 1, 32'h0000_0037);
    chk("b28_pc", pc, 32'hFFFF_FFFC);

    // Misaligned target faults and freezes; later acks are ignored.
    cyc(1, 1, 32'h0000_0006, 0, 0);
    cyc(1, 0, 0, 1, 32'h0000_0033);
    chk("b36_pc", pc, 32'hFFFF_FFFC);

    // Illegal opcode halts; nothing moves until reset.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'h0000_007F);
    chk("b35_fault", {31'b0, fault}, 32'h1);
    cyc(1, 1, 32'h0000_0010, 1, 32'h0000_0033);
    cyc(1, 0, 0, 1, 32'h0000_0013);

    // Reset colliding with an ack discards the word and refetches.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 32'h0000_0020, 1, 32'h0000_0033);
    chk("b38_insn", insn, NOP);
    cyc(1, 0, 0, 1, 32'h0000_100F);

    // Randomized traffic: mostly legal words and aligned targets.
    for (int i = 0; i < 600; i++) begin
      u = $urandom; v = $urandom;
      if (u[3:0] == 4'hF) w = v;
      else begin
        w = v;
        w[6:0] = op_tab[$urandom_range(0, 10)];
      end
      nx = $urandom;
      if (u[7:5] != 3'b000) nx[1:0] = 2'b00;
      cyc(u[15:10] != 6'd0, u[17:16] == 2'b00, nx, u[18], w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
